// File: rtl/clct_patid_sched_pkg.sv
// Shared constants and FSM state type for the CLCT pattern-ID scheduler.
package clct_patid_sched_pkg;

    localparam logic [4:0] PID_NONE      = 5'd31;
    localparam logic [4:0] PID_L1ONLY    = 5'd30;
    localparam logic [4:0] PID_PAIR_OFS  = 5'd5;
    localparam logic [2:0] PID_MAX_LEGAL = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/clct_patid_sched_pair_enc.sv
// Combinational encoder: CLCT0/CLCT1 (vpf, pid) pair -> 5-bit combined code plus error flag.
module patid_pair_enc
    import clct_patid_sched_pkg::*;
(
    input  logic       lct0_vpf,
    input  logic [2:0] clct0_pid,
    input  logic       lct1_vpf,
    input  logic [2:0] clct1_pid,
    output logic       err,
    output logic [4:0] code
);

    logic [5:0] pair_sum;

    always_comb begin
        // Pair code is formed 6 bits wide and deliberately truncated, even for illegal PIDs.
        pair_sum = (6'(clct1_pid) * 6'd5) + 6'(clct0_pid) + 6'(PID_PAIR_OFS);
        unique case ({lct0_vpf, lct1_vpf})
            2'b10:   code = {2'b00, clct0_pid};
            2'b11:   code = pair_sum[4:0];
            2'b01:   code = PID_L1ONLY;
            default: code = PID_NONE;
        endcase
        err = (lct0_vpf && (clct0_pid > PID_MAX_LEGAL)) ||
              (lct1_vpf && (clct1_pid > PID_MAX_LEGAL));
    end

endmodule

// File: rtl/clct_patid_sched.sv
// Per-BX CLCT pattern-ID scheduler: encode stage, inline FIFO with overflow count, valid/ready output.
module clct_patid_sched
    import clct_patid_sched_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned BXW        = 12,
    parameter bit          DROP_EMPTY = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    in_valid,
    input  logic                    lct0_vpf,
    input  logic [2:0]              clct0_pid,
    input  logic                    lct1_vpf,
    input  logic [2:0]              clct1_pid,
    input  logic [BXW-1:0]          in_bxn,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4:0]              out_pid,
    output logic [BXW-1:0]          out_bxn,
    output logic                    out_err,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic [7:0]              ovf_count,
    output logic                    busy
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned WW       = BXW + 6;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

    state_t         state;
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [AW:0]    count;
    logic [WW-1:0]  mem [DEPTH];
    logic           s1_valid;
    logic [WW-1:0]  s1_word;
    logic           enc_err;
    logic [4:0]     enc_code;
    logic           fifo_empty;
    logic           fifo_full;
    logic           take;
    logic           pop;
    logic           bypass;
    logic           push;
    logic           drop;
    logic [WW-1:0]  head;

    patid_pair_enc u_enc (
        .lct0_vpf  (lct0_vpf),
        .clct0_pid (clct0_pid),
        .lct1_vpf  (lct1_vpf),
        .clct1_pid (clct1_pid),
        .err       (enc_err),
        .code      (enc_code)
    );

    always_comb begin
        count      = wr_ptr - rd_ptr;
        fifo_empty = (count == '0);
        fifo_full  = (count == FULL_CNT);
        // The output register is free to load in IDLE, or in SEND when its word is being taken.
        take       = !flush && ((state == IDLE) || ((state == SEND) && out_ready));
        pop        = take && !fifo_empty;
        // An empty FIFO lets stage 1 load the output register directly, giving the 2-cycle latency.
        bypass     = take && fifo_empty && s1_valid;
        push       = !flush && s1_valid && !bypass && (!fifo_full || pop);
        drop       = !flush && s1_valid && !bypass && fifo_full && !pop;
        head       = pop ? mem[rd_ptr[AW-1:0]] : s1_word;
    end

    always_ff @(posedge clock) begin
        if (reset_n && push) begin
            mem[wr_ptr[AW-1:0]] <= s1_word;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            s1_valid  <= 1'b0;
            s1_word   <= '0;
            out_valid <= 1'b0;
            out_pid   <= '0;
            out_bxn   <= '0;
            out_err   <= 1'b0;
            ovf_count <= '0;
        end else if (flush) begin
            state     <= FLUSH;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_pid   <= '0;
            out_bxn   <= '0;
            out_err   <= 1'b0;
        end else begin
            s1_valid <= (state != FLUSH) && in_valid &&
                        !(DROP_EMPTY && !lct0_vpf && !lct1_vpf);
            s1_word  <= {enc_err, enc_code, in_bxn};
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (drop && (ovf_count != 8'hFF)) begin
                ovf_count <= ovf_count + 8'd1;
            end
            unique case (state)
                IDLE, SEND: begin
                    if (pop || bypass) begin
                        state     <= SEND;
                        out_valid <= 1'b1;
                        out_err   <= head[WW-1];
                        out_pid   <= head[WW-2 -: 5];
                        out_bxn   <= head[BXW-1:0];
                    end else if (take) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    wr_ptr    <= '0;
                    rd_ptr    <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_count = count;
    assign busy       = (count != '0) || out_valid || s1_valid;

endmodule
